// File: rtl/random_range.sv
// Bounded random draw: a bank of 8-bit Fibonacci LFSR cells feeds a rejection sampler
// that delivers a value in 0..RANGE-1, falling back to a deterministic value after MAX_TRIES rejects.
module random_range #(
    parameter int WIDTH     = 8,
    parameter int RANGE     = 9,
    parameter int OUT_W     = 4,
    parameter int MAX_TRIES = 8,
    parameter int NO_REPEAT = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load_seed,
    input  logic [8*WIDTH-1:0]   seed,
    input  logic                 req,
    output logic [WIDTH-1:0]     data,
    output logic [OUT_W-1:0]     value,
    output logic                 valid,
    output logic                 busy
);

    typedef enum logic {IDLE, DRAW} state_t;

    localparam logic [OUT_W-1:0] LAST_VAL    = OUT_W'(RANGE - 1);
    localparam logic [7:0]       LAST_TRY    = 8'(MAX_TRIES - 1);

    state_t                  state_q, state_d;
    logic [WIDTH-1:0][7:0]   cell_q, cell_d;
    logic [OUT_W-1:0]        value_q, value_d;
    logic [OUT_W-1:0]        fb_cnt_q, fb_cnt_d;
    logic [7:0]              try_q, try_d;
    logic                    valid_q, valid_d;
    logic                    has_prev_q, has_prev_d;
    logic [OUT_W-1:0]        candidate;
    logic [OUT_W-1:0]        fallback;
    logic                    reject;

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed byte becomes 8'hFF.
    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (s == 8'h00) ? 8'hFF : s;
    endfunction

    function automatic logic [7:0] reset_seed(input int i);
        return seed_fix(8'((29 + 37 * i) % 256));
    endfunction

    always_comb begin
        data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            data[i] = cell_q[i][0];
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cell_d = cell_q;
        if (load_seed) begin
            for (int i = 0; i < WIDTH; i++) begin
                cell_d[i] = seed_fix(seed[8*i +: 8]);
            end
        end else if (enable || state_q == DRAW) begin
            for (int i = 0; i < WIDTH; i++) begin
                cell_d[i] = lfsr_step(cell_q[i]);
            end
        end
    end

    assign candidate = data[OUT_W-1:0];
    assign reject    = (32'(candidate) >= 32'(RANGE)) ||
                       ((NO_REPEAT != 0) && has_prev_q && (candidate == value_q));
    assign fallback  = ((NO_REPEAT != 0) && has_prev_q)
                       ? ((value_q == LAST_VAL) ? '0 : value_q + OUT_W'(1))
                       : fb_cnt_q;
    assign fb_cnt_d  = (fb_cnt_q == LAST_VAL) ? '0 : fb_cnt_q + OUT_W'(1);

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        has_prev_d = has_prev_q;
        try_d      = try_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (!reject || try_q == LAST_TRY) begin
                    value_d    = reject ? fallback : candidate;
                    valid_d    = 1'b1;
                    has_prev_d = 1'b1;
                    state_d    = IDLE;
                    try_d      = '0;
                end else begin
                    try_d = try_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            value_q    <= '0;
            fb_cnt_q   <= '0;
            try_q      <= '0;
            valid_q    <= 1'b0;
            has_prev_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cell_q[i] <= reset_seed(i);
            end
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            fb_cnt_q   <= fb_cnt_d;
            try_q      <= try_d;
            valid_q    <= valid_d;
            has_prev_q <= has_prev_d;
            cell_q     <= cell_d;
        end
    end

    assign value = value_q;
    assign valid = valid_q;
    assign busy  = (state_q == DRAW);

endmodule

// File: tb/tb_random_range.sv
// Scoreboard bench for random_range: a cycle model predicts each draw when the request is taken
// and the monitor compares delivered values and their arrival cycle; a second instance covers NO_REPEAT.
module tb_random_range;

    localparam int W         = 8;
    localparam int RANGE     = 9;
    localparam int OUT_W     = 4;
    localparam int MAX_TRIES = 8;

    typedef logic [W-1:0][7:0] cells_t;
    typedef struct {
        int value;
        int cyc;
    } exp_t;

    logic             clock;
    logic             reset;
    logic             enable, load_seed, req;
    logic [8*W-1:0]   seed;
    logic [W-1:0]     data;
    logic [OUT_W-1:0] value;
    logic             valid, busy;

    logic             nr_load, nr_req;
    logic [8*W-1:0]   nr_seed;
    logic [W-1:0]     nr_data;
    logic [OUT_W-1:0] nr_value;
    logic             nr_valid, nr_busy;

    int        n_checks = 0;
    int        n_fail   = 0;
    int        cyc      = 0;
    int        n_req    = 0;
    bit        mon_en   = 0;
    bit        prev_valid = 0;
    logic [RANGE-1:0] seen = '0;

    cells_t    m_cells;
    int        m_fb = 0;
    int        m_draw_left = 0;
    exp_t      sb_q[$];

    random_range dut (
        .clock(clock), .reset(reset), .enable(enable), .load_seed(load_seed),
        .seed(seed), .req(req), .data(data), .value(value), .valid(valid), .busy(busy)
    );

    random_range #(.MAX_TRIES(4), .NO_REPEAT(1)) dut_nr (
        .clock(clock), .reset(reset), .enable(1'b0), .load_seed(nr_load),
        .seed(nr_seed), .req(nr_req), .data(nr_data), .value(nr_value),
        .valid(nr_valid), .busy(nr_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [7:0] fix_seed(input logic [7:0] s);
        return (s == 8'h00) ? 8'hFF : s;
    endfunction

    function automatic cells_t step_all(input cells_t c);
        cells_t r;
        for (int i = 0; i < W; i++) r[i] = lfsr_step(c[i]);
        return r;
    endfunction

    function automatic cells_t load_cells(input logic [8*W-1:0] s);
        cells_t r;
        for (int i = 0; i < W; i++) r[i] = fix_seed(s[8*i +: 8]);
        return r;
    endfunction

    function automatic cells_t default_cells();
        cells_t r;
        for (int i = 0; i < W; i++) r[i] = fix_seed(8'((29 + 37 * i) % 256));
        return r;
    endfunction

    function automatic logic [W-1:0] data_of(input cells_t c);
        logic [W-1:0] d;
        for (int i = 0; i < W; i++) d[i] = c[i][0];
        return d;
    endfunction

    // Cycle model of the default instance; a taken request is resolved to its final value at once.
    task automatic model_step();
        bit           was_draw;
        cells_t       c;
        logic [W-1:0] d;
        int           fb, cand, val, n;
        exp_t         e;
        was_draw = (m_draw_left > 0);
        if (reset) begin
            m_cells     = default_cells();
            m_fb        = 0;
            m_draw_left = 0;
            sb_q.delete();
            cyc++;
            return;
        end
        if (!was_draw && req) begin
            c   = load_seed ? load_cells(seed) : (enable ? step_all(m_cells) : m_cells);
            fb  = m_fb;
            n   = 0;
            val = 0;
            for (int k = 1; k <= MAX_TRIES; k++) begin
                fb   = (fb + 1) % RANGE;
                d    = data_of(c);
                cand = int'(d[OUT_W-1:0]);
                if (cand < RANGE) begin
                    val = cand;
                    n   = k;
                    break;
                end
                if (k == MAX_TRIES) begin
                    val = fb;
                    n   = k;
                end
                c = step_all(c);
            end
            e.value = val;
            e.cyc   = cyc + n + 1;
            sb_q.push_back(e);
            m_draw_left = n;
            n_req++;
        end else if (was_draw) begin
            m_draw_left--;
        end
        if (load_seed)              m_cells = load_cells(seed);
        else if (enable || was_draw) m_cells = step_all(m_cells);
        m_fb = (m_fb + 1) % RANGE;
        cyc++;
    endtask

    task automatic monitor_step();
        exp_t e;
        check("data", 32'(data), 32'(data_of(m_cells)));
        check("busy", 32'(busy), 32'(m_draw_left > 0));
        if (valid) begin
            check("valid_width", 32'(prev_valid), 0);
            check("value_range", 32'(int'(value) < RANGE), 1);
            if (int'(value) < RANGE) seen[value] = 1'b1;
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'(valid), 0);
            end else begin
                e = sb_q.pop_front();
                check("value", 32'(value), 32'(e.value));
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end else if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
            check("missing_valid", 32'(cyc), 32'(sb_q[0].cyc));
            void'(sb_q.pop_front());
        end
        prev_valid = valid;
    endtask

    initial forever @(posedge clock) model_step();

    initial forever begin
        @(negedge clock);
        if (mon_en) monitor_step();
    end

    task automatic wait_nr_valid(input string tag, input int exp_cyc, input int exp_val);
        int got = -1;
        for (int i = 0; i < 30; i++) begin
            if (nr_valid) begin
                got = cyc;
                break;
            end
            @(negedge clock);
        end
        check({tag, "_cyc"}, 32'(got), 32'(exp_cyc));
        check({tag, "_val"}, 32'(nr_value), 32'(exp_val));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq[5];
        int         t, guard;
        seq = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
        reset = 1'b1; enable = 1'b0; load_seed = 1'b0; seed = '0; req = 1'b0;
        nr_load = 1'b0; nr_req = 1'b0; nr_seed = '0;
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        check("rst_data", 32'(data), 32'h55);
        check("rst_value", 32'(value), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_nr_value", 32'(nr_value), 0);

        // Seed 01 everywhere and free-run.
        @(negedge clock); seed = {W{8'h01}}; load_seed = 1'b1; enable = 1'b1;
        @(negedge clock); load_seed = 1'b0;
        check("seed01_data0", 32'(data), 32'(seq[0]));
        for (int i = 1; i < 5; i++) begin
            @(negedge clock);
            check("seed01_data", 32'(data), 32'(seq[i]));
        end
        enable = 1'b0;

        // Zero seed is substituted with FF.
        @(negedge clock); seed = '0; load_seed = 1'b1;
        @(negedge clock); load_seed = 1'b0;
        check("seed00_data", 32'(data), 32'hFF);
        enable = 1'b1;
        @(negedge clock); enable = 1'b0;
        check("seed00_step", 32'(data), 32'h00);

        // Reset in the second DRAW cycle aborts a draw that would otherwise deliver.
        @(negedge clock); seed = {W{8'hFF}}; load_seed = 1'b1;
        @(negedge clock); load_seed = 1'b0; req = 1'b1;
        @(negedge clock); req = 1'b0;
        check("abort_busy_draw", 32'(busy), 1);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(valid), 0);
        check("abort_data", 32'(data), 32'h55);
        repeat (3) begin
            @(negedge clock);
            check("abort_no_valid", 32'(valid), 0);
        end

        // Bulk random requests with random stepping.
        guard = 0;
        while (n_req < 2000 && guard < 40000) begin
            @(negedge clock);
            req    = ($urandom_range(0, 7) != 0);
            enable = 1'($urandom_range(0, 1));
            guard++;
        end
        check("requests_issued", 32'(n_req >= 2000), 1);

        // Continuous request: back-to-back draws.
        req = 1'b1;
        repeat (200) @(negedge clock);
        req = 1'b0;
        enable = 1'b0;
        repeat (20) @(negedge clock);
        check("all_values_seen", 32'(seen), 32'h1FF);
        check("sb_drained", 32'(sb_q.size()), 0);

        // NO_REPEAT instance: first draw accepted, second exhausts tries and falls back.
        @(negedge clock); nr_seed = {W{8'h02}}; nr_load = 1'b1;
        @(negedge clock); nr_load = 1'b0; nr_req = 1'b1; t = cyc;
        @(negedge clock); nr_req = 1'b0;
        wait_nr_valid("nr_first", t + 2, 0);
        nr_req = 1'b1; t = cyc;
        @(negedge clock); nr_req = 1'b0;
        check("nr_valid_width", 32'(nr_valid), 0);
        wait_nr_valid("nr_fallback", t + 5, 1);
        @(negedge clock);
        check("nr_value_hold", 32'(nr_value), 1);

        // Reload mid-draw keeps the try count, so the fallback still lands after 4 rejects.
        @(negedge clock); nr_seed = {W{8'h11}}; nr_load = 1'b1;
        @(negedge clock); nr_load = 1'b0; nr_req = 1'b1; t = cyc;
        @(negedge clock); nr_req = 1'b0;
        @(negedge clock); nr_load = 1'b1;
        @(negedge clock); nr_load = 1'b0;
        check("nr_load_busy", 32'(nr_busy), 1);
        wait_nr_valid("nr_load_mid_draw", t + 5, 2);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/random_range.md
RANDOM_RANGE -- requirements
Module: random_range

Interface
REQ-001 Parameter WIDTH, 8: number of LFSR cells, which is also the raw output width; legal values 2..16.
REQ-002 Parameter RANGE, 9: draw range; value is in 0..RANGE-1; legal values 2..2^WIDTH.
REQ-003 Parameter OUT_W, 4: value width; OUT_W = clog2(RANGE) and OUT_W <= WIDTH.
REQ-004 Parameter MAX_TRIES, 8: rejected draws allowed before the fallback value is used; legal values 1..255.
REQ-005 Parameter NO_REPEAT, 0: when 1, a draw equal to the previous delivered value is rejected.
REQ-006 Ports (one clock; reset is synchronous and active-high):
- clock      in   1          rising-edge clock
- reset      in   1          synchronous, active-high reset
- enable     in   1          free-run step enable for the cells
- load_seed  in   1          load all cells from seed
- seed       in   8*WIDTH    cell i seed at bits [8i+7:8i]
- req        in   1          draw request
- data       out  WIDTH      data[i] = bit0 of cell i
- value      out  OUT_W      last delivered draw
- valid      out  1          one-cycle pulse: value updated
- busy       out  1          draw in progress

Function
REQ-007 Each cell SHALL be an 8-bit Fibonacci LFSR; step: q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}; period 255.
REQ-008 Cells SHALL step in a cycle when (enable || state==DRAW) && !load_seed && !reset.
REQ-009 load_seed SHALL load every cell from its seed byte on the next edge, with priority over stepping; a zero seed byte SHALL load 8'hFF instead.
REQ-010 data SHALL be combinational from cell bit0 and SHALL reflect the cell registers directly.
REQ-011 FSM states: IDLE, DRAW. IDLE->DRAW when req=1; req SHALL be ignored in DRAW. busy = (state==DRAW).
REQ-012 In each DRAW cycle: candidate = data[OUT_W-1:0]; reject if candidate >= RANGE, or if NO_REPEAT=1 && has_prev && candidate==value.
REQ-013 On accept: value <= candidate, valid=1 in the next cycle, has_prev <= 1, state <= IDLE, try counter <= 0.
REQ-014 On reject: try counter increments; on the MAX_TRIES-th reject, value <= fallback, valid=1 next cycle, state <= IDLE.
REQ-015 Fallback: (value+1) mod RANGE when NO_REPEAT=1 && has_prev; otherwise fb_cnt, a free-running counter that runs 0..RANGE-1, increments every cycle and wraps to 0.
REQ-016 Latency: req at cycle t with immediate accept -> valid at t+2; worst case valid at t+1+MAX_TRIES.
REQ-017 value SHALL hold between valid pulses; valid SHALL never be high for 2 consecutive cycles.
REQ-018 load_seed during DRAW SHALL reload the cells without aborting the draw or clearing the try counter.
REQ-019 A req asserted in the same cycle that valid is high SHALL be accepted, because state is IDLE in that cycle.

Reset
REQ-020 Reset SHALL force state=IDLE, valid=0, value=0, has_prev=0, try counter=0 and fb_cnt=0.
REQ-021 Reset SHALL load cell i with (8'h1D + 37*i) mod 256, with the zero-substitution rule of REQ-009 applied.
REQ-022 Reset during DRAW SHALL abort the draw; no valid pulse is produced for the aborted request.

Verification
REQ-023 Seed all cells 8'h01, load_seed, enable=1 -> data sequence FF, 00, 00, 00, FF across successive cycles.
REQ-024 Seed all cells 8'h00, load_seed -> cells = 8'hFF and data = FF; after one step, cells = 8'hFE and data = 00.
REQ-025 WIDTH=8, RANGE=9: issue 2000 requests -> every value < 9, every value 0..8 seen, each valid exactly one cycle wide.
REQ-026 NO_REPEAT=1, MAX_TRIES=4, all cells seeded 8'h02, enable=0:
- first req -> value 0 at t+2
- second req -> all candidates are 0 or 15 and are rejected -> value 1 at t+5
REQ-027 Assert reset in the second DRAW cycle -> valid stays 0, busy=0 next cycle, data equals the default seed bit pattern.
REQ-028 Hold req high continuously -> valid pulses are separated by >= 1 cycle, and busy drops exactly in each valid cycle.
